ex_muldiv: RTL and testbench
============================

// Module: ex_muldiv
// PURPOSE
//  Multi-cycle multiply/divide unit for the EX stage, with architectural HI/LO registers.
//  Executes MULT/MULTU on a pipelined multiplier of MUL_LAT cycles.
//  Executes DIV/DIVU on an iterative restoring divider that produces one quotient bit per cycle.
//  Also executes MTHI/MTLO. Drives stallreq_o, which the EX stage ORs into its stall request.
// PARAMETERS
//  DATA_W   32  operand/HI/LO width
//  MUL_LAT  2   multiply latency in cycles, legal range 1..4
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, synchronous, active-high
//  start_i    in   1       op_i/opnd*_i valid; held high by EX while stalled
//  op_i       in   3       000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO
//  opnd1_i    in   DATA_W  multiplicand / dividend / MT source
//  opnd2_i    in   DATA_W  multiplier / divisor
//  flush_i    in   1       annul the in-flight op (exception / pipeline flush)
//  stallreq_o out  1       hold the pipeline
//  done_o     out  1       high in the cycle HI/LO takes a mul/div result
//  hi_o       out  DATA_W  HI register
//  lo_o       out  DATA_W  LO register
// BEHAVIOUR
//  Reset: state=IDLE; hi_o, lo_o=0; stallreq_o=0; done_o=0; divider and multiplier pipe cleared.
//   Reset applies in any state, including mid-operation.
//  States: IDLE, MUL, DIV, FINISH.
//  start_i is sampled only in IDLE. It is ignored in MUL, DIV and FINISH, so a held instruction never restarts.
//  IDLE:
//   - MTHI/MTLO: write hi_o/lo_o at this edge, no stall; value visible next cycle.
//   - MULT/MULTU: latch operands, then go to MUL (MUL_LAT>1) or FINISH (MUL_LAT=1).
//   - DIV/DIVU with divisor!=0: latch magnitudes, count=0, go to DIV.
//   - DIV/DIVU with divisor==0: go to FINISH with result HI=opnd1_i, LO={DATA_W{1}}.
//  MUL: stays MUL_LAT-1 cycles, then goes to FINISH.
//  DIV: one restoring step per cycle; after DATA_W steps (count==DATA_W-1) goes to FINISH.
//  FINISH:
//   - done_o=1; {HI,LO} written at the end of this cycle; next state IDLE.
//   - EX advances on the same edge.
//  stallreq_o is combinational:
//   - 1 in IDLE when start_i & op is mul/div & !flush_i.
//   - 1 throughout MUL and DIV.
//   - 0 in FINISH.
//   - Stall length: MUL_LAT cycles for a multiply, DATA_W+1 for a divide, 1 for divide-by-zero.
//  Arithmetic:
//   - MULT signed / MULTU unsigned, 2*DATA_W product: HI=upper half, LO=lower half.
//   - DIV: divide magnitudes, then sign-fix in FINISH. Quotient is negated iff operand signs differ;
//     remainder takes the sign of the dividend. LO=quotient, HI=remainder.
//   - MIN_INT / -1 wraps: LO=0x80000000, HI=0.
//  Counter width: $clog2(DATA_W+1).
//  flush_i:
//   - Has priority over start_i and over all states.
//   - Next state is IDLE; HI/LO unchanged; stallreq_o=0 and done_o=0 in the flush cycle.
//   - A flush in FINISH also suppresses the HI/LO write.
//  Undefined op codes (111) are treated as NOP.
// TESTING
//  1. MULT 0xFFFFFFFE*3, MUL_LAT=2 -> stallreq_o high 2 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; done_o one pulse.
//  2. MULTU 0xFFFFFFFE*3 -> HI=0x00000002, LO=0xFFFFFFFA.
//  3. DIV -7/2 -> stallreq_o high exactly 33 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
//  4. DIVU 0x64/0 -> 1 stall cycle; HI=0x64, LO=0xFFFFFFFF. DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
//  5. DIV started, flush_i in its 10th cycle -> stallreq_o=0 that cycle; IDLE next; HI/LO unchanged.
//     Then MTLO 0x1234 -> lo_o=0x1234 next cycle, no stall.
//  6. rst asserted mid-DIV -> next cycle IDLE, HI=LO=0, stallreq_o=0.
//     start_i held high through FINISH -> no second execution.

Source files
------------

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - EX-stage multi-cycle multiply/divide unit with HI/LO registers
module ex_muldiv #(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] opnd1_i,
    input  logic [DATA_W-1:0] opnd2_i,
    input  logic              flush_i,
    output logic              stallreq_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    localparam int CNT_W    = $clog2(DATA_W + 1);
    localparam int MUL_LAST = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FINISH} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   rem_q, rem_d, quot_q, quot_d, dvsr_q, dvsr_d;
    logic                q_neg_q, q_neg_d, r_neg_q, r_neg_d, is_mul_q, is_mul_d;
    logic [2*DATA_W-1:0] mul_pipe_q [MUL_LAT];
    logic [2*DATA_W-1:0] mul_pipe_d [MUL_LAT];

    logic                is_mul_op, is_div_op, a_neg, b_neg;
    logic [DATA_W-1:0]   a_mag, b_mag, quot_fix, rem_fix;
    logic [2*DATA_W-1:0] mul_a, mul_b, product, mul_res;
    logic [DATA_W:0]     rem_shift, rem_diff;

    always_comb begin
        is_mul_op = start_i && (op_i == OP_MULT || op_i == OP_MULTU);
        is_div_op = start_i && (op_i == OP_DIV || op_i == OP_DIVU);
        a_neg     = (op_i == OP_DIV) && opnd1_i[DATA_W-1];
        b_neg     = (op_i == OP_DIV) && opnd2_i[DATA_W-1];
        a_mag     = a_neg ? -opnd1_i : opnd1_i;
        b_mag     = b_neg ? -opnd2_i : opnd2_i;
        mul_a     = {{DATA_W{(op_i == OP_MULT) && opnd1_i[DATA_W-1]}}, opnd1_i};
        mul_b     = {{DATA_W{(op_i == OP_MULT) && opnd2_i[DATA_W-1]}}, opnd2_i};
        product   = mul_a * mul_b;
        mul_res   = mul_pipe_q[MUL_LAT-1];
        quot_fix  = q_neg_q ? -quot_q : quot_q;
        rem_fix   = r_neg_q ? -rem_q : rem_q;
        // Restoring step: shift next dividend bit into the partial remainder, subtract if it fits
        rem_shift = {rem_q, quot_q[DATA_W-1]};
        rem_diff  = rem_shift - {1'b0, dvsr_q};

        stallreq_o = !flush_i && ((state_q == S_IDLE && (is_mul_op || is_div_op)) ||
                                  state_q == S_MUL || state_q == S_DIV);
        done_o     = !flush_i && (state_q == S_FINISH);

        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        count_d  = count_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        dvsr_d   = dvsr_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        is_mul_d = is_mul_q;
        mul_pipe_d[0] = mul_pipe_q[0];
        for (int i = 1; i < MUL_LAT; i++) mul_pipe_d[i] = mul_pipe_q[i-1];

        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        count_d = '0;
                        case (op_i)
                            OP_MTHI: hi_d = opnd1_i;
                            OP_MTLO: lo_d = opnd1_i;
                            OP_MULT, OP_MULTU: begin
                                mul_pipe_d[0] = product;
                                is_mul_d      = 1'b1;
                                state_d       = (MUL_LAT > 1) ? S_MUL : S_FINISH;
                            end
                            OP_DIV, OP_DIVU: begin
                                is_mul_d = 1'b0;
                                if (opnd2_i == '0) begin
                                    rem_d   = opnd1_i;
                                    quot_d  = '1;
                                    q_neg_d = 1'b0;
                                    r_neg_d = 1'b0;
                                    state_d = S_FINISH;
                                end else begin
                                    rem_d   = '0;
                                    quot_d  = a_mag;
                                    dvsr_d  = b_mag;
                                    q_neg_d = a_neg ^ b_neg;
                                    r_neg_d = a_neg;
                                    state_d = S_DIV;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (count_q == CNT_W'(MUL_LAST)) state_d = S_FINISH;
                    else count_d = count_q + 1'b1;
                end
                S_DIV: begin
                    if (!rem_diff[DATA_W]) begin
                        rem_d  = rem_diff[DATA_W-1:0];
                        quot_d = {quot_q[DATA_W-2:0], 1'b1};
                    end else begin
                        rem_d  = rem_shift[DATA_W-1:0];
                        quot_d = {quot_q[DATA_W-2:0], 1'b0};
                    end
                    if (count_q == CNT_W'(DATA_W - 1)) state_d = S_FINISH;
                    else count_d = count_q + 1'b1;
                end
                S_FINISH: begin
                    if (is_mul_q) begin
                        hi_d = mul_res[2*DATA_W-1:DATA_W];
                        lo_d = mul_res[DATA_W-1:0];
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            count_q  <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            dvsr_q   <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            is_mul_q <= 1'b0;
            for (int i = 0; i < MUL_LAT; i++) mul_pipe_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            count_q  <= count_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            dvsr_q   <= dvsr_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            is_mul_q <= is_mul_d;
            for (int i = 0; i < MUL_LAT; i++) mul_pipe_q[i] <= mul_pipe_d[i];
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - vector-table and scoreboard bench for ex_muldiv
module tb_ex_muldiv;
    logic        clk = 1'b0;
    logic        rst, start_i, flush_i, stallreq_o, done_o;
    logic [2:0]  op_i;
    logic [31:0] opnd1_i, opnd2_i, hi_o, lo_o;

    ex_muldiv #(.DATA_W(32), .MUL_LAT(2)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .opnd1_i(opnd1_i), .opnd2_i(opnd2_i), .flush_i(flush_i),
        .stallreq_o(stallreq_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
        int          stall;
    } vec_t;
    typedef struct {
        logic [31:0] hi, lo;
    } exp_t;

    vec_t vecs[17];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input string tag);
        exp_t e;
        int   stalls = 0;
        bit   seen = 0;
        bit   ended = 0;
        @(negedge clk);
        start_i = 1'b1; op_i = v.op; opnd1_i = v.a; opnd2_i = v.b;
        sb.push_back('{v.hi, v.lo});
        for (int c = 0; c < 60; c++) begin
            #1;
            if (stallreq_o) stalls++;
            if (done_o) seen = 1'b1;
            if (!stallreq_o) begin
                ended = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check($sformatf("%s completes", tag), 32'(ended), 32'd1);
        @(negedge clk);
        start_i = 1'b0; op_i = 3'd0;
        #1;
        e = sb.pop_front();
        check($sformatf("%s stall cycles", tag), 32'(stalls), 32'(v.stall));
        check($sformatf("%s done pulse", tag), 32'(seen), 32'(v.stall != 0));
        check($sformatf("%s done cleared", tag), 32'(done_o), 32'd0);
        check($sformatf("%s hi", tag), hi_o, e.hi);
        check($sformatf("%s lo", tag), lo_o, e.lo);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   dones;
        bit   got_done;
        vecs[0]  = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 2};
        vecs[1]  = '{3'd2, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 2};
        vecs[2]  = '{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 2};
        vecs[3]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 2};
        vecs[4]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[5]  = '{3'd4, 32'd100,      32'd7,        32'd2,        32'd14,       33};
        vecs[6]  = '{3'd4, 32'h00000064, 32'd0,        32'h00000064, 32'hFFFFFFFF, 1};
        vecs[7]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
        vecs[8]  = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
        vecs[9]  = '{3'd3, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 33};
        vecs[10] = '{3'd3, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1};
        vecs[11] = '{3'd4, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 33};
        vecs[12] = '{3'd5, 32'h0000CAFE, 32'd9,        32'h0000CAFE, 32'hFFFFFFFF, 0};
        vecs[13] = '{3'd6, 32'h0000BEEF, 32'd9,        32'h0000CAFE, 32'h0000BEEF, 0};
        vecs[14] = '{3'd0, 32'd1,        32'd2,        32'h0000CAFE, 32'h0000BEEF, 0};
        vecs[15] = '{3'd7, 32'd1,        32'd2,        32'h0000CAFE, 32'h0000BEEF, 0};
        vecs[16] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2};

        rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = 3'd0; opnd1_i = '0; opnd2_i = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset hi", hi_o, 32'd0);
        check("reset lo", lo_o, 32'd0);
        check("reset stallreq", 32'(stallreq_o), 32'd0);
        check("reset done", 32'(done_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // Flush a divide in its 10th stall cycle, then MTLO
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd3; opnd1_i = 32'd100; opnd2_i = 32'd3;
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        #1;
        check("flush div stallreq", 32'(stallreq_o), 32'd0);
        check("flush div done", 32'(done_o), 32'd0);
        @(negedge clk);
        flush_i = 1'b0; start_i = 1'b0; op_i = 3'd0;
        #1;
        check("post flush stallreq", 32'(stallreq_o), 32'd0);
        check("post flush hi", hi_o, 32'hFFFFFFFE);
        check("post flush lo", lo_o, 32'h00000001);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (done_o) dones++;
        end
        check("flushed div never completes", 32'(dones), 32'd0);
        run_op('{3'd6, 32'h00001234, 32'd0, 32'hFFFFFFFE, 32'h00001234, 0}, "mtlo after flush");

        // Flush arriving in FINISH suppresses the HI/LO write
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd1; opnd1_i = 32'd3; opnd2_i = 32'd5;
        sb.push_back('{32'hFFFFFFFE, 32'h00001234});
        got_done = 1'b0;
        for (int c = 0; c < 10 && !got_done; c++) begin
            #1;
            if (done_o) got_done = 1'b1;
            else @(negedge clk);
        end
        check("finish flush reached finish", 32'(got_done), 32'd1);
        flush_i = 1'b1;
        #1;
        check("finish flush done", 32'(done_o), 32'd0);
        check("finish flush stallreq", 32'(stallreq_o), 32'd0);
        @(negedge clk);
        flush_i = 1'b0; start_i = 1'b0; op_i = 3'd0;
        #1;
        e = sb.pop_front();
        check("finish flush hi", hi_o, e.hi);
        check("finish flush lo", lo_o, e.lo);

        // Reset in the middle of a divide
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd4; opnd1_i = 32'd1000; opnd2_i = 32'd7;
        repeat (5) @(negedge clk);
        rst = 1'b1; start_i = 1'b0; op_i = 3'd0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid-div reset hi", hi_o, 32'd0);
        check("mid-div reset lo", lo_o, 32'd0);
        check("mid-div reset stallreq", 32'(stallreq_o), 32'd0);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (done_o) dones++;
        end
        check("reset div never completes", 32'(dones), 32'd0);

        run_op('{3'd4, 32'd100, 32'd7, 32'd2, 32'd14, 33}, "divu after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
